// File: rtl/mips32_prog_harness.sv
// mips32_prog_harness
//   Program-load / run / result-dump sequencer for the mips32 core.
//   Streams a program image into unified memory, releases the core, waits for
//   hlt (bounded by TIMEOUT), then reads a fixed memory window back out over a
//   valid/ready stream.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   start, prog_len          kick off a sequence (IDLE/DONE only), word count
//   prog_valid/ready/data    program image stream in
//   mem_we/re/addr/wdata     memory port; mem_rdata valid 1 cycle after mem_re
//   cpu_run, cpu_halted      core release / hlt indication
//   dump_valid/ready/addr/data  result window stream out
//   busy, done, timeout_err, run_cycles  status
module mips32_prog_harness #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int PROG_DEPTH = 64,
  parameter int DUMP_BASE  = 120,
  parameter int DUMP_LEN   = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [15:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_RD_REQ, S_RD_WAIT, S_DUMP, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'((DUMP_LEN > 0) ? DUMP_LEN - 1 : 0);
  localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   len, wcnt, idx, len_in, rd_addr, acap;
  logic [DATA_W-1:0]   dcap;
  logic [31:0]         rcnt;   // cycles spent in RUN; wide so TIMEOUT is not capped at 16 bits
  logic                accept, halt_ok, to_hit, go;

  // prog_len beyond the image buffer is clipped; the clipped branch can only
  // be taken when PROG_DEPTH < 2**ADDR_W, so the cast never truncates.
  assign len_in  = (32'(prog_len) > PROG_DEPTH) ? ADDR_W'(PROG_DEPTH) : prog_len;
  assign go      = start && (state == S_IDLE || state == S_DONE);
  assign accept  = (state == S_LOAD) && prog_valid;
  // First RUN cycle (rcnt==0) ignores a halt left over from a previous program.
  assign halt_ok = (rcnt != 32'd0) && cpu_halted;
  assign to_hit  = (rcnt == TO_LAST);
  assign rd_addr = BASE_A + idx;   // wraps modulo 2**ADDR_W

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= '0;
      wcnt        <= '0;
      idx         <= '0;
      rcnt        <= '0;
      dcap        <= '0;
      acap        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        len         <= len_in;
        wcnt        <= '0;
        idx         <= '0;
        rcnt        <= '0;
        timeout_err <= 1'b0;
      end
      if (accept) wcnt <= wcnt + ADDR_W'(1);
      if (state == S_RUN) begin
        rcnt <= rcnt + 32'd1;
        if (to_hit && !halt_ok) timeout_err <= 1'b1;
      end
      if (state == S_RD_WAIT) begin
        dcap <= mem_rdata;
        acap <= rd_addr;
      end
      if (state == S_DUMP && dump_ready) idx <= idx + ADDR_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) nxt = (len_in == '0) ? S_RUN : S_LOAD;
      S_LOAD:    if (accept && wcnt == len - ADDR_W'(1)) nxt = S_RUN;
      S_RUN:     if (halt_ok || to_hit) nxt = (DUMP_LEN == 0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  nxt = S_RD_WAIT;
      S_RD_WAIT: nxt = S_DUMP;
      S_DUMP:    if (dump_ready) nxt = (idx == LAST_I) ? S_DONE : S_RD_REQ;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    prog_ready = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_run    = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    unique case (state)
      S_LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_addr  = wcnt;
          mem_wdata = prog_data;
        end
      end
      S_RUN:    cpu_run = 1'b1;
      S_RD_REQ: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr;
      end
      S_DUMP: begin
        dump_valid = 1'b1;
        dump_addr  = acap;
        dump_data  = dcap;
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign run_cycles = (|rcnt[31:16]) ? 16'hFFFF : rcnt[15:0];

endmodule

// File: tb/tb_mips32_prog_harness.sv
// Directed bench for mips32_prog_harness with a behavioural memory and a
// stub core that halts a set number of cycles after release (or never).
module tb_mips32_prog_harness;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [9:0]  prog_len = '0;
  logic        prog_valid = 1'b0;
  logic [31:0] prog_data = '0;
  logic        prog_ready, mem_we, mem_re, cpu_run, cpu_halted;
  logic [9:0]  mem_addr, dump_addr;
  logic [31:0] mem_wdata, mem_rdata, dump_data;
  logic        dump_valid, dump_ready = 1'b1, busy, done, timeout_err;
  logic [15:0] run_cycles;

  mips32_prog_harness #(.DATA_W(32), .ADDR_W(10), .PROG_DEPTH(64),
                        .DUMP_BASE(120), .DUMP_LEN(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done),
    .timeout_err(timeout_err), .run_cycles(run_cycles));

  always #5 clk = ~clk;

  // memory + stub core: "program" stores mem[120]+45 into mem[121] on halt
  logic [31:0] mem [1024];
  int          halt_after = 6;
  logic        force_halt = 1'b0;
  int          core_cnt = 0;
  always @(posedge clk) begin
    if (rst) mem[120] <= 32'd85;
    else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (cpu_run && cpu_halted) mem[121] <= mem[120] + 32'd45;
    end
  end
  always @(posedge clk) core_cnt <= cpu_run ? core_cnt + 1 : 0;
  assign cpu_halted = force_halt || (halt_after != 0 && core_cnt >= halt_after);

  // monitors (cumulative; tests take baselines)
  logic [9:0]  wa_q[$], da_q[$];
  logic [31:0] wd_q[$], dd_q[$];
  int run_cnt = 0, re_cnt = 0, bub_err = 0, both_err = 0;
  always @(negedge clk) if (!rst) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata);
      if (!prog_valid) bub_err++;
    end
    if (mem_we && mem_re) both_err++;
    if (cpu_run) run_cnt++;
    if (mem_re) re_cnt++;
    if (dump_valid && dump_ready) begin
      da_q.push_back(dump_addr); dd_q.push_back(dump_data);
    end
  end

  logic [31:0] img [8];
  int checks = 0, errors = 0;
  int wb, db, rb, reb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    wb = wa_q.size(); db = da_q.size(); rb = run_cnt; reb = re_cnt;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; prog_len = 10'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input bit gap, input bit alt);
    int w;
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_data  = alt ? 32'hA000_0000 + 32'(i) : img[i];
      w = 0;
      do begin @(negedge clk); w++; end while (!prog_ready && w < 200);
      if (!prog_ready) begin
        chk("load_ready", {31'd0, prog_ready}, 32'd1);
        prog_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      prog_valid = 1'b0;
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (!done && w < 500) begin @(negedge clk); w++; end
    chk(tag, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_dump();
    chk("dump_n", 32'(da_q.size() - db), 32'd2);
    if (da_q.size() - db == 2) begin
      chk("dump0_a", 32'(da_q[db]),   32'd120);
      chk("dump0_d", dd_q[db],        32'd85);
      chk("dump1_a", 32'(da_q[db+1]), 32'd121);
      chk("dump1_d", dd_q[db+1],      32'd130);
    end
  endtask

  task automatic chk_writes8();
    chk("wr_n", 32'(wa_q.size() - wb), 32'd8);
    if (wa_q.size() - wb == 8)
      for (int i = 0; i < 8; i++) begin
        chk("wr_a", 32'(wa_q[wb+i]), 32'(i));
        chk("wr_d", wd_q[wb+i], img[i]);
      end
  endtask

  initial begin
    logic [9:0]  sa;
    logic [31:0] sd;
    img = '{32'h28010078, 32'h0ce77800, 32'h20220000, 32'h0ce77800,
            32'h2842002d, 32'h0ce77800, 32'h24220001, 32'hfc000000};
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {prog_ready, mem_we, mem_re, cpu_run, dump_valid, timeout_err},
        32'd0);
    chk("rst_rc", {16'd0, run_cycles}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: normal load, halt after 7 RUN cycles
    snap();
    do_start(8);
    load_words(8, 1'b0, 1'b0);
    wait_done("t1_done");
    chk_writes8();
    chk("t1_to", {31'd0, timeout_err}, 32'd0);
    chk("t1_rc", {16'd0, run_cycles}, 32'd7);
    chk("t1_run", 32'(run_cnt - rb), 32'd7);
    chk_dump();

    // 2: bubbles between words
    snap();
    do_start(8);
    load_words(8, 1'b1, 1'b0);
    wait_done("t2_done");
    chk_writes8();
    chk("t2_bubble", 32'(bub_err), 32'd0);

    // 3: core never halts -> timeout after 20 cycles, dump still runs
    halt_after = 0;
    snap();
    do_start(8);
    load_words(8, 1'b0, 1'b0);
    wait_done("t3_done");
    chk("t3_run", 32'(run_cnt - rb), 32'd20);
    chk("t3_rc", {16'd0, run_cycles}, 32'd20);
    chk("t3_to", {31'd0, timeout_err}, 32'd1);
    chk_dump();
    halt_after = 6;

    // 4: empty program with stale halt -> RUN exactly 2 cycles
    force_halt = 1'b1;
    snap();
    do_start(0);
    wait_done("t4_done");
    chk("t4_wr", 32'(wa_q.size() - wb), 32'd0);
    chk("t4_run", 32'(run_cnt - rb), 32'd2);
    chk("t4_rc", {16'd0, run_cycles}, 32'd2);
    chk("t4_to", {31'd0, timeout_err}, 32'd0);
    chk_dump();

    // 5: consumer stalls the first dump word for 5 cycles
    dump_ready = 1'b0;
    snap();
    do_start(0);
    for (int w = 0; w < 100 && !dump_valid; w++) @(negedge clk);
    chk("t5_valid", {31'd0, dump_valid}, 32'd1);
    sa = dump_addr; sd = dump_data;
    chk("t5_a", {22'd0, sa}, 32'd120);
    chk("t5_d", sd, 32'd85);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold", {dump_valid, 21'd0, dump_addr}, {1'b1, 21'd0, sa});
      chk("t5_hold_d", dump_data, sd);
      chk("t5_re", 32'(re_cnt - reb), 32'd1);
    end
    dump_ready = 1'b1;
    wait_done("t5_done");
    chk("t5_re_all", 32'(re_cnt - reb), 32'd2);
    chk_dump();
    force_halt = 1'b0;

    // 6: reset mid-LOAD, then an over-long program clipped to 64 words
    do_start(8);
    load_words(3, 1'b0, 1'b0);
    prog_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst", {busy, done, prog_ready, mem_we, mem_re, cpu_run, dump_valid,
                   timeout_err}, 32'd0);
    chk("t6_rst_rc", {16'd0, run_cycles}, 32'd0);
    prog_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    snap();
    do_start(100);
    load_words(64, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_ready_off", {31'd0, prog_ready}, 32'd0);
    wait_done("t6_done");
    chk("t6_wr_n", 32'(wa_q.size() - wb), 32'd64);
    if (wa_q.size() - wb == 64) begin
      chk("t6_last_a", 32'(wa_q[wb+63]), 32'd63);
      chk("t6_last_d", wd_q[wb+63], 32'hA000_003F);
    end
    chk_dump();

    chk("we_re_excl", 32'(both_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
